// File: rtl/arb_mux_n.sv
// arb_mux_n: N-way, WIDTH-bit registered multiplexer with valid/ready
// handshakes on every input channel and on the output.
//
// The grant is chosen combinationally. MODE=0 uses round-robin arbitration,
// scanning upward from the channel after the last winner. MODE=1 forwards
// the channel named by sel_ext.
//
// The winning word is captured in a one-entry output register. That register
// may be reloaded on the same edge it is drained, so throughput is one word
// per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   per-channel offer
//   in_data    channel i occupies bits [i*WIDTH +: WIDTH]
//   in_ready   per-channel accept (one-hot or zero)
//   sel_ext    channel to forward when MODE=1
//   out_valid  output register holds data
//   out_data   registered data
//   out_src    index of the channel that supplied out_data
//   out_ready  downstream accepts the output this cycle
module arb_mux_n #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N),
  parameter int MODE  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel_ext,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  input  logic               out_ready
);

  // One extra bit so that rr_ptr + k (at most 2N-1) does not overflow.
  localparam int CW = SELW + 1;
  localparam logic [CW-1:0] N_C = CW'(N);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_src_q,   out_src_d;
  logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

  logic             load_en_s;
  logic             gnt_found_s;
  logic [SELW-1:0]  gnt_idx_s;
  logic [CW-1:0]    cand_s;

  assign load_en_s = !out_valid_q | out_ready;

  // Grant selection: round-robin scan or external select.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    cand_s      = '0;
    if (MODE == 0) begin
      // Visit rr_ptr+1 .. rr_ptr+N modulo N. The first valid channel wins,
      // so indices >= N are never reached, even when N is not a power of 2.
      for (int k = 1; k <= N; k++) begin
        cand_s = {1'b0, rr_ptr_q} + CW'(k);
        if (cand_s >= N_C) begin
          cand_s = cand_s - N_C;
        end else begin
          cand_s = cand_s;
        end
        if (!gnt_found_s && in_valid[cand_s[SELW-1:0]]) begin
          gnt_found_s = 1'b1;
          gnt_idx_s   = cand_s[SELW-1:0];
        end else begin
          gnt_found_s = gnt_found_s;
        end
      end
    end else begin
      if (({1'b0, sel_ext} < N_C) && in_valid[sel_ext]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = sel_ext;
      end else begin
        gnt_found_s = 1'b0;
      end
    end
  end

  // Accept strobe: only the granted channel, only when the register can load.
  always_comb begin
    in_ready = '0;
    if (rst_n && load_en_s && gnt_found_s) begin
      in_ready[gnt_idx_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  // Next-state logic for the output register and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en_s) begin
      if (gnt_found_s) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data[int'(gnt_idx_s)*WIDTH +: WIDTH];
        out_src_d   = gnt_idx_s;
        if (MODE == 0) begin
          rr_ptr_d = gnt_idx_s;
        end else begin
          rr_ptr_d = rr_ptr_q;
        end
      end else begin
        // Drain without refill: data and source are kept for observability.
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers. Reset places the pointer at N-1 so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= SELW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// tb_arb_mux_n: directed bench for arb_mux_n.
//
// Two instances share their inputs: u_rr in round-robin mode and u_ext in
// external-select mode. Expected output words are pushed to a scoreboard
// queue as each transfer is set up, then popped and compared once the word
// appears on the output.
module tb_arb_mux_n;

  localparam int W = 32;
  localparam int N = 4;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [S-1:0]   sel_ext;
  logic           out_ready;

  logic [N-1:0]   rr_in_ready,  ex_in_ready;
  logic           rr_out_valid, ex_out_valid;
  logic [W-1:0]   rr_out_data,  ex_out_data;
  logic [S-1:0]   rr_out_src,   ex_out_src;

  int n_checks = 0;
  int n_err    = 0;

  logic [S+W-1:0] sb_q[$];

  arb_mux_n #(.WIDTH(W), .N(N), .MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rr_in_ready), .sel_ext(sel_ext), .out_valid(rr_out_valid),
    .out_data(rr_out_data), .out_src(rr_out_src), .out_ready(out_ready)
  );

  arb_mux_n #(.WIDTH(W), .N(N), .MODE(1)) u_ext (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ex_in_ready), .sel_ext(sel_ext), .out_valid(ex_out_valid),
    .out_data(ex_out_data), .out_src(ex_out_src), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the word expected from a transfer at the next edge, clock, then
  // pop it and compare against the round-robin instance's output.
  task automatic rr_xfer(input string tag, input logic [S-1:0] src);
    logic [S+W-1:0] e;
    sb_q.push_back({src, W'(32'hA0) + W'(src)});
    tick();
    e = sb_q.pop_front();
    chk({tag, "_valid"}, 64'(rr_out_valid), 64'd1);
    chk({tag, "_src"},   64'(rr_out_src),   64'(e[S+W-1:W]));
    chk({tag, "_data"},  64'(rr_out_data),  64'(e[W-1:0]));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    sel_ext   = 2'd0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA0 + 32'(i);

    // T1: reset state
    tick();
    tick();
    chk("rst_valid",    64'(rr_out_valid), 64'd0);
    chk("rst_data",     64'(rr_out_data),  64'd0);
    chk("rst_src",      64'(rr_out_src),   64'd0);
    chk("rst_ready",    64'(rr_in_ready),  64'd0);
    chk("rst_ex_ready", 64'(ex_in_ready),  64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_first_gnt", 64'(rr_in_ready), 64'(4'b0001));

    // T2: round-robin, one word per cycle
    rr_xfer("rr0", 2'd0);
    rr_xfer("rr1", 2'd1);
    rr_xfer("rr2", 2'd2);
    rr_xfer("rr3", 2'd3);
    rr_xfer("rr4", 2'd0);

    // T3: backpressure holds everything, then grant resumes at rr_ptr+1
    out_ready = 1'b0;
    #1;
    chk("bp_ready0", 64'(rr_in_ready), 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_valid", 64'(rr_out_valid), 64'd1);
      chk("bp_src",   64'(rr_out_src),   64'd0);
      chk("bp_data",  64'(rr_out_data),  64'(32'hA0));
      chk("bp_ready", 64'(rr_in_ready),  64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_gnt", 64'(rr_in_ready), 64'(4'b0010));
    rr_xfer("bp_resume", 2'd1);

    // T4: reach rr_ptr=0, then sparse valids wrap 3,0,3
    in_valid = 4'b0001;
    rr_xfer("sp_setup", 2'd0);
    in_valid = 4'b1001;
    rr_xfer("sp_a", 2'd3);
    rr_xfer("sp_b", 2'd0);
    rr_xfer("sp_c", 2'd3);
    in_valid = 4'b0000;
    #1;
    chk("drain_ready", 64'(rr_in_ready), 64'd0);
    tick();
    chk("drain_valid", 64'(rr_out_valid), 64'd0);
    chk("drain_src",   64'(rr_out_src),   64'd3);
    chk("drain_data",  64'(rr_out_data),  64'(32'hA3));

    // T5: external select
    sel_ext  = 2'd2;
    in_valid = 4'b0110;
    #1;
    chk("ext_ready", 64'(ex_in_ready), 64'(4'b0100));
    tick();
    chk("ext_valid", 64'(ex_out_valid), 64'd1);
    chk("ext_src",   64'(ex_out_src),   64'd2);
    chk("ext_data",  64'(ex_out_data),  64'(32'hA2));
    sel_ext = 2'd0;
    #1;
    chk("ext_nogrant_ready", 64'(ex_in_ready), 64'd0);
    tick();
    chk("ext_nogrant_valid", 64'(ex_out_valid), 64'd0);

    // T6: reset while the output is stalled with a held word
    in_valid = 4'hF;
    tick();
    out_ready = 1'b0;
    #1;
    chk("mid_pre_valid", 64'(rr_out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(rr_in_ready), 64'd0);
    tick();
    chk("mid_valid", 64'(rr_out_valid), 64'd0);
    chk("mid_data",  64'(rr_out_data),  64'd0);
    chk("mid_src",   64'(rr_out_src),   64'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mid_ptr_gnt", 64'(rr_in_ready), 64'(4'b0001));
    rr_xfer("mid_first", 2'd0);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
